// File: rtl/mips_arb_pkg.sv
// Shared definitions for the Harvard-core memory arbiter.
// Provides the arbiter FSM state type, the all-lanes byte enable used for
// instruction fetches, and the default waitrequest tolerance per access.
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_ACC  = 2'd1,
        INSTR_ACC = 2'd2,
        RELEASE   = 2'd3
    } arb_state_t;

    localparam logic [3:0] BE_ALL           = 4'b1111;
    localparam int         DEFAULT_MAX_WAIT = 255;

endpackage

// File: rtl/mips_arb_wait_counter.sv
// Saturating waitrequest counter for one bus access.
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-low reset (0 = reset)
//   i_clear    restart the count at zero (wins over i_enable)
//   i_enable   count one waitrequest cycle
//   o_expired  count has reached MAX_WAIT; the access must be abandoned
module mips_arb_wait_counter
    import mips_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int               CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Saturates at MAX_WAIT so the counter can never wrap back to "not expired".
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_ONE;
        end
    end

    assign o_expired = (r_count == CNT_MAX);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one Avalon-style memory port between the instruction and data ports
// of the Harvard CPU core. Requests of one CPU cycle are latched in IDLE,
// served serially (data first, since it belongs to the older instruction),
// and the core is released for exactly one cycle via o_cpu_clk_enable.
// Ports:
//   i_clk, i_reset            clock, synchronous active-low reset (0 = reset)
//   i_instr_*                 fetch request / o_instr_readdata, o_instr_valid
//   i_data_*                  load/store request / o_data_readdata, o_data_valid
//   o_cpu_clk_enable          core advances only while this is 1
//   o_mem_*, i_mem_*          shared bus; completes when strobe & !waitrequest
//   o_timeout_err             sticky flag: an access hit MAX_WAIT wait cycles
module mips_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_instr_req,
    input  logic [ADDR_W-1:0] i_instr_address,
    output logic [DATA_W-1:0] o_instr_readdata,
    output logic              o_instr_valid,
    input  logic              i_data_read,
    input  logic              i_data_write,
    input  logic [ADDR_W-1:0] i_data_address,
    input  logic [DATA_W-1:0] i_data_writedata,
    input  logic [3:0]        i_data_byteenable,
    output logic [DATA_W-1:0] o_data_readdata,
    output logic              o_data_valid,
    output logic              o_cpu_clk_enable,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [DATA_W-1:0] o_mem_writedata,
    output logic [3:0]        o_mem_byteenable,
    input  logic              i_mem_waitrequest,
    input  logic [DATA_W-1:0] i_mem_readdata,
    output logic              o_timeout_err
);

    arb_state_t        r_state;
    logic              r_pend_d;
    logic              r_pend_i;
    logic              r_is_write;
    logic [ADDR_W-1:0] r_data_addr;
    logic [ADDR_W-1:0] r_instr_addr;
    logic [DATA_W-1:0] r_writedata;
    logic [3:0]        r_byteenable;
    logic [DATA_W-1:0] r_data_readdata;
    logic [DATA_W-1:0] r_instr_readdata;
    logic              r_data_valid;
    logic              r_instr_valid;
    logic              r_timeout_err;

    arb_state_t        w_next_state;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_cpu_clk_enable;
    logic              w_data_done;
    logic              w_instr_done;
    logic              w_abort;
    logic              w_cnt_clear;
    logic              w_cnt_enable;
    logic              w_expired;

    mips_arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // An expired counter ends the access without a strobe in that cycle:
    // it is reported as done with w_abort set so the datapath loads zero.
    always_comb begin
        w_next_state     = r_state;
        w_mem_read       = 1'b0;
        w_mem_write      = 1'b0;
        w_cpu_clk_enable = 1'b0;
        w_data_done      = 1'b0;
        w_instr_done     = 1'b0;
        w_abort          = 1'b0;
        w_cnt_clear      = 1'b1;
        w_cnt_enable     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_data_read || i_data_write) begin
                    w_next_state = DATA_ACC;
                end else if (i_instr_req) begin
                    w_next_state = INSTR_ACC;
                end
            end
            DATA_ACC: begin
                w_cnt_clear = 1'b0;
                if (w_expired) begin
                    w_abort      = 1'b1;
                    w_data_done  = 1'b1;
                    w_cnt_clear  = 1'b1;
                    w_next_state = r_pend_i ? INSTR_ACC : RELEASE;
                end else begin
                    w_mem_write = r_pend_d & r_is_write;
                    w_mem_read  = r_pend_d & ~r_is_write;
                    if (i_mem_waitrequest) begin
                        w_cnt_enable = 1'b1;
                    end else begin
                        w_data_done  = 1'b1;
                        w_cnt_clear  = 1'b1;
                        w_next_state = r_pend_i ? INSTR_ACC : RELEASE;
                    end
                end
            end
            INSTR_ACC: begin
                w_cnt_clear = 1'b0;
                if (w_expired) begin
                    w_abort      = 1'b1;
                    w_instr_done = 1'b1;
                    w_cnt_clear  = 1'b1;
                    w_next_state = RELEASE;
                end else begin
                    w_mem_read = 1'b1;
                    if (i_mem_waitrequest) begin
                        w_cnt_enable = 1'b1;
                    end else begin
                        w_instr_done = 1'b1;
                        w_cnt_clear  = 1'b1;
                        w_next_state = RELEASE;
                    end
                end
            end
            RELEASE: begin
                w_cpu_clk_enable = 1'b1;
                w_next_state     = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Request registers follow the core while idle; the core holds its
    // requests stable while stalled, so the last IDLE sample is the one served.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pend_d         <= 1'b0;
            r_pend_i         <= 1'b0;
            r_is_write       <= 1'b0;
            r_data_addr      <= '0;
            r_instr_addr     <= '0;
            r_writedata      <= '0;
            r_byteenable     <= '0;
            r_data_readdata  <= '0;
            r_instr_readdata <= '0;
            r_data_valid     <= 1'b0;
            r_instr_valid    <= 1'b0;
            r_timeout_err    <= 1'b0;
        end else begin
            r_data_valid  <= 1'b0;
            r_instr_valid <= 1'b0;
            if (r_state == IDLE) begin
                r_pend_d     <= i_data_read | i_data_write;
                r_pend_i     <= i_instr_req;
                r_is_write   <= i_data_write;
                r_data_addr  <= i_data_address;
                r_instr_addr <= i_instr_address;
                r_writedata  <= i_data_writedata;
                r_byteenable <= i_data_byteenable;
            end
            if (w_data_done) begin
                r_pend_d     <= 1'b0;
                r_data_valid <= 1'b1;
                if (w_abort) begin
                    r_data_readdata <= '0;
                end else if (!r_is_write) begin
                    r_data_readdata <= i_mem_readdata;
                end
            end
            if (w_instr_done) begin
                r_pend_i         <= 1'b0;
                r_instr_valid    <= 1'b1;
                r_instr_readdata <= w_abort ? '0 : i_mem_readdata;
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_mem_read       = w_mem_read;
    assign o_mem_write      = w_mem_write;
    assign o_mem_address    = (r_state == INSTR_ACC) ? r_instr_addr : r_data_addr;
    assign o_mem_byteenable = (r_state == INSTR_ACC) ? BE_ALL : r_byteenable;
    assign o_mem_writedata  = r_writedata;
    assign o_cpu_clk_enable = w_cpu_clk_enable;
    assign o_data_readdata  = r_data_readdata;
    assign o_instr_readdata = r_instr_readdata;
    assign o_data_valid     = r_data_valid;
    assign o_instr_valid    = r_instr_valid;
    assign o_timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter (built with MAX_WAIT = 4).
// A transaction-level reference model predicts, for each CPU cycle's request
// set, the ordered list of bus accesses, the cycle the core is released, the
// valid pulses, the readdata registers and the sticky timeout flag.
module tb_mips_mem_arbiter;

    localparam int MAX_WAIT_TB = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_instr_req;
    logic [31:0] i_instr_address;
    logic [31:0] o_instr_readdata;
    logic        o_instr_valid;
    logic        i_data_read;
    logic        i_data_write;
    logic [31:0] i_data_address;
    logic [31:0] i_data_writedata;
    logic [3:0]  i_data_byteenable;
    logic [31:0] o_data_readdata;
    logic        o_data_valid;
    logic        o_cpu_clk_enable;
    logic [31:0] o_mem_address;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [31:0] o_mem_writedata;
    logic [3:0]  o_mem_byteenable;
    logic        i_mem_waitrequest;
    logic [31:0] i_mem_readdata;
    logic        o_timeout_err;

    int          compareCount  = 0;
    int          mismatchCount = 0;

    logic [31:0] expData;
    logic [31:0] expInstr;
    logic        expTmo;

    mips_mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MAX_WAIT_TB)
    ) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_instr_req       (i_instr_req),
        .i_instr_address   (i_instr_address),
        .o_instr_readdata  (o_instr_readdata),
        .o_instr_valid     (o_instr_valid),
        .i_data_read       (i_data_read),
        .i_data_write      (i_data_write),
        .i_data_address    (i_data_address),
        .i_data_writedata  (i_data_writedata),
        .i_data_byteenable (i_data_byteenable),
        .o_data_readdata   (o_data_readdata),
        .o_data_valid      (o_data_valid),
        .o_cpu_clk_enable  (o_cpu_clk_enable),
        .o_mem_address     (o_mem_address),
        .o_mem_read        (o_mem_read),
        .o_mem_write       (o_mem_write),
        .o_mem_writedata   (o_mem_writedata),
        .o_mem_byteenable  (o_mem_byteenable),
        .i_mem_waitrequest (i_mem_waitrequest),
        .i_mem_readdata    (i_mem_readdata),
        .o_timeout_err     (o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [79:0] observed,
                               input logic [79:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Cycles an access occupies: one per wait plus the completing cycle, or
    // MAX_WAIT wait cycles plus the abandon cycle when the bus never answers.
    function automatic int accessCycles(input int waits);
        return (waits >= MAX_WAIT_TB) ? MAX_WAIT_TB + 1 : waits + 1;
    endfunction

    // Presents one CPU cycle's requests in an IDLE cycle, plays the bus side
    // (waits per access, then the given word) and checks against the model.
    task automatic applyStimulus(input logic dr, input logic dw,
                                 input logic [31:0] daddr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic ireq,
                                 input logic [31:0] iaddr, input int dWait,
                                 input int iWait, input logic [31:0] dWord,
                                 input logic [31:0] iWord);
        logic [79:0] expAcc [2];
        int          accWait [2];
        logic [31:0] accWord [2];
        logic [79:0] obsAcc;
        int          nAcc;
        int          k;
        int          waitSoFar;
        int          totalCycles;
        int          expEnCycle;
        int          enCycle;
        int          dValidCnt;
        int          iValidCnt;
        int          budget;
        bit          active;
        bit          strobe;

        nAcc        = 0;
        totalCycles = 0;
        if (dr || dw) begin
            expAcc[nAcc]  = {dw, dr & ~dw, be, daddr, dw ? wdata : 32'h0};
            accWait[nAcc] = dWait;
            accWord[nAcc] = dWord;
            totalCycles  += accessCycles(dWait);
            if (dWait >= MAX_WAIT_TB) begin
                expData = 32'h0;
                expTmo  = 1'b1;
            end else if (!dw) begin
                expData = dWord;
            end
            nAcc++;
        end
        if (ireq) begin
            expAcc[nAcc]  = {1'b0, 1'b1, 4'b1111, iaddr, 32'h0};
            accWait[nAcc] = iWait;
            accWord[nAcc] = iWord;
            totalCycles  += accessCycles(iWait);
            if (iWait >= MAX_WAIT_TB) begin
                expInstr = 32'h0;
                expTmo   = 1'b1;
            end else begin
                expInstr = iWord;
            end
            nAcc++;
        end
        expEnCycle = (nAcc == 0) ? -1 : totalCycles + 1;
        budget     = (nAcc == 0) ? 10 : totalCycles + 4;

        i_data_read       = dr;
        i_data_write      = dw;
        i_data_address    = daddr;
        i_data_writedata  = wdata;
        i_data_byteenable = be;
        i_instr_req       = ireq;
        i_instr_address   = iaddr;

        k         = 0;
        waitSoFar = 0;
        active    = 1'b0;
        enCycle   = -1;
        dValidCnt = 0;
        iValidCnt = 0;
        for (int cyc = 0; cyc < budget && enCycle < 0; cyc++) begin
            if (o_data_valid)     dValidCnt++;
            if (o_instr_valid)    iValidCnt++;
            if (o_cpu_clk_enable) enCycle = cyc;
            strobe            = o_mem_read | o_mem_write;
            i_mem_readdata    = $urandom;
            i_mem_waitrequest = 1'b0;
            if (strobe) begin
                if (k < nAcc) begin
                    obsAcc = {o_mem_write, o_mem_read, o_mem_byteenable, o_mem_address,
                              o_mem_write ? o_mem_writedata : 32'h0};
                    checkOutput("busAccess", obsAcc, expAcc[k]);
                    if (waitSoFar < accWait[k]) begin
                        i_mem_waitrequest = 1'b1;
                        waitSoFar++;
                        active = 1'b1;
                    end else begin
                        i_mem_readdata = accWord[k];
                        k++;
                        waitSoFar = 0;
                        active    = 1'b0;
                    end
                end else begin
                    checkOutput("extraAccess", 80'(strobe), 80'd0);
                end
            end else if (active) begin
                k++;
                waitSoFar = 0;
                active    = 1'b0;
            end
            @(posedge i_clk);
            #1;
        end
        i_mem_waitrequest = 1'b0;

        checkOutput("cpuEnCycle", 80'(enCycle), 80'(expEnCycle));
        checkOutput("cpuEnOnce", 80'(o_cpu_clk_enable), 80'd0);
        checkOutput("accessCount", 80'(k), 80'(nAcc));
        checkOutput("dataValidPulses", 80'(dValidCnt), 80'((dr || dw) ? 1 : 0));
        checkOutput("instrValidPulses", 80'(iValidCnt), 80'(ireq ? 1 : 0));
        checkOutput("dataReaddata", 80'(o_data_readdata), 80'(expData));
        checkOutput("instrReaddata", 80'(o_instr_readdata), 80'(expInstr));
        checkOutput("timeoutErr", 80'(o_timeout_err), 80'(expTmo));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        dr;
        logic        dw;
        logic        ireq;
        int          dWait;
        int          iWait;

        i_reset           = 1'b0;
        i_instr_req       = 1'b0;
        i_instr_address   = 32'h0;
        i_data_read       = 1'b0;
        i_data_write      = 1'b0;
        i_data_address    = 32'h0;
        i_data_writedata  = 32'h0;
        i_data_byteenable = 4'h0;
        i_mem_waitrequest = 1'b0;
        i_mem_readdata    = 32'h0;
        expData           = 32'h0;
        expInstr          = 32'h0;
        expTmo            = 1'b0;

        repeat (3) @(posedge i_clk);
        #1;
        checkOutput("rstMemRead", 80'(o_mem_read), 80'd0);
        checkOutput("rstMemWrite", 80'(o_mem_write), 80'd0);
        checkOutput("rstCpuEn", 80'(o_cpu_clk_enable), 80'd0);
        checkOutput("rstTimeout", 80'(o_timeout_err), 80'd0);
        checkOutput("rstDataRd", 80'(o_data_readdata), 80'd0);
        checkOutput("rstInstrRd", 80'(o_instr_readdata), 80'd0);
        checkOutput("rstValids", 80'({o_data_valid, o_instr_valid}), 80'd0);
        checkOutput("rstMemAddr", 80'(o_mem_address), 80'd0);
        checkOutput("rstMemBe", 80'(o_mem_byteenable), 80'd0);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;

        $display("[TB] directed: fetch only");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 0, 0, 32'h0, 32'h8C080064);
        $display("[TB] directed: load plus fetch");
        applyStimulus(1'b1, 1'b0, 32'd100, 32'h0, 4'hF, 1'b1, 32'd4, 0, 0, 32'd9, 32'hAC080000);
        $display("[TB] directed: store with three wait cycles");
        applyStimulus(1'b0, 1'b1, 32'd100, 32'd9, 4'b0011, 1'b0, 32'h0, 3, 0, 32'h0, 32'h0);
        $display("[TB] directed: idle");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 0, 0, 32'h0, 32'h0);
        $display("[TB] directed: fetch timeout");
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h40, 0, 100, 32'h0, 32'h12345678);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h44, 0, 1, 32'h0, 32'hCAFEF00D);

        $display("[TB] directed: reset during data access");
        i_data_read       = 1'b1;
        i_data_write      = 1'b0;
        i_data_address    = 32'h200;
        i_data_byteenable = 4'hF;
        i_instr_req       = 1'b1;
        i_instr_address   = 32'h48;
        i_mem_waitrequest = 1'b1;
        @(posedge i_clk);
        #1;
        checkOutput("midAccRead", 80'(o_mem_read), 80'd1);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("midRstStrobes", 80'({o_mem_read, o_mem_write}), 80'd0);
        checkOutput("midRstValids", 80'({o_data_valid, o_instr_valid}), 80'd0);
        checkOutput("midRstCpuEn", 80'(o_cpu_clk_enable), 80'd0);
        checkOutput("midRstTimeout", 80'(o_timeout_err), 80'd0);
        checkOutput("midRstReaddata", 80'({o_data_readdata, o_instr_readdata}), 80'd0);
        i_reset           = 1'b1;
        i_data_read       = 1'b0;
        i_instr_req       = 1'b0;
        i_mem_waitrequest = 1'b0;
        expData           = 32'h0;
        expInstr          = 32'h0;
        expTmo            = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("postRstCpuEn", 80'(o_cpu_clk_enable), 80'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h4C, 0, 0, 32'h0, 32'h2402000A);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 60; n++) begin
            dr    = 1'($urandom_range(0, 1));
            dw    = 1'($urandom_range(0, 1));
            ireq  = 1'($urandom_range(0, 1));
            dWait = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
            iWait = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(0, 3);
            applyStimulus(dr, dw, $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom),
                          ireq, $urandom & 32'hFFFF_FFFC, dWait, iWait, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
